// File: rtl/uvmt_apb_st_clknrst_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// uvmt_apb_st_clknrst_ctrl_pkg
//   Shared types and defaults for the APB self-test clock-enable / reset
//   sequencer.
//   - state_e   : sequencer FSM states
//   - DEF_*     : default parameter values for the top and the divider
//   - idx_width : width of the channel index for a given channel count
// ----------------------------------------------------------------------------
package uvmt_apb_st_clknrst_ctrl_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_DIV_W      = 8;
    localparam int DEF_DLY_W      = 8;
    localparam int DEF_SW_RST_CYC = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2,
        SWRST   = 2'd3
    } state_e;

    // A single channel still needs a 1-bit index register.
    function automatic int idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/uvmt_apb_st_clknrst_div.sv
// ----------------------------------------------------------------------------
// uvmt_apb_st_clknrst_div
//   One channel's clock-enable divider. The ratio is latched on restart, so
//   later changes on the ratio input have no effect until the next restart.
//   Ratio N>=2 gives a one-cycle strobe every N cycles, the first strobe in
//   the cycle right after the restart edge; N=0/1 holds the strobe high.
//
//   clk     in   free-running clock
//   reset   in   synchronous, active-high reset (strobe low, counters 0)
//   restart in   latch ratio and restart the phase
//   run     in   advance the divider
//   ratio   in   DIV_W divide ratio
//   clk_en  out  registered clock-enable strobe
// ----------------------------------------------------------------------------
module uvmt_apb_st_clknrst_div
    import uvmt_apb_st_clknrst_ctrl_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             run,
    input  logic [DIV_W-1:0] ratio,
    output logic             clk_en
);

    logic [DIV_W-1:0] ratio_q;
    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ratio_q <= '0;
            cnt_q   <= '0;
            clk_en  <= 1'b0;
        end else if (restart) begin
            // Strobe goes high on the restart edge itself: phase 0.
            ratio_q <= ratio;
            cnt_q   <= '0;
            clk_en  <= 1'b1;
        end else if (run) begin
            if (ratio_q <= DIV_W'(1)) begin
                cnt_q  <= '0;
                clk_en <= 1'b1;
            end else if (cnt_q == ratio_q - DIV_W'(1)) begin
                cnt_q  <= '0;
                clk_en <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + DIV_W'(1);
                clk_en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uvmt_apb_st_clknrst_ctrl.sv
// ----------------------------------------------------------------------------
// uvmt_apb_st_clknrst_ctrl
//   Clock-enable and reset sequencer for the APB self-test bench. Generates
//   NUM_CH divided clock-enable strobes and NUM_CH reset pairs from one clock.
//   After a start, channel resets are released in index order, channel i
//   waiting rst_dly[i]+1 cycles after the previous one.
//
//   Optional feature macro: UVMT_APB_ST_CLKNRST_CTRL_SW_RST_EN
//     When defined, sw_rst_req in DONE pulses ch_reset on the masked channels
//     for SW_RST_CYC cycles. When undefined, sw_rst_req/sw_rst_mask are
//     ignored and the SWRST state is unreachable.
//
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   sequence request (pulse or level), taken in IDLE/DONE
//   div_ratio    in   NUM_CH*DIV_W per-channel divide ratios
//   rst_dly      in   NUM_CH*DLY_W per-channel release delays
//   sw_rst_req   in   software reset request
//   sw_rst_mask  in   NUM_CH channels targeted by sw_rst_req
//   ch_clk_en    out  NUM_CH clock-enable strobes
//   ch_reset     out  NUM_CH active-high channel resets
//   ch_reset_n   out  NUM_CH complement of ch_reset
//   busy         out  release sequence or software reset in progress
//   done         out  all channels released
// ----------------------------------------------------------------------------
module uvmt_apb_st_clknrst_ctrl
    import uvmt_apb_st_clknrst_ctrl_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int DLY_W      = DEF_DLY_W,
    parameter int SW_RST_CYC = DEF_SW_RST_CYC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic [NUM_CH*DLY_W-1:0] rst_dly,
    input  logic                    sw_rst_req,
    input  logic [NUM_CH-1:0]       sw_rst_mask,
    output logic [NUM_CH-1:0]       ch_clk_en,
    output logic [NUM_CH-1:0]       ch_reset,
    output logic [NUM_CH-1:0]       ch_reset_n,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = idx_width(NUM_CH);

    logic [NUM_CH-1:0][DIV_W-1:0] div_in;
    logic [NUM_CH-1:0][DLY_W-1:0] dly_in;

    assign div_in = div_ratio;
    assign dly_in = rst_dly;

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q,   idx_d;
    logic [DLY_W-1:0]             cnt_q,   cnt_d;
    logic [NUM_CH-1:0]            rst_q,   rst_d;
    logic                         busy_d,  done_d;
    logic [NUM_CH-1:0][DLY_W-1:0] dly_sh_q;
    logic                         accept;
    logic                         last;

    assign last = (idx_q == IDX_W'(NUM_CH - 1));

`ifdef UVMT_APB_ST_CLKNRST_CTRL_SW_RST_EN
    localparam int SW_W = (SW_RST_CYC > 1) ? $clog2(SW_RST_CYC) : 1;

    logic [SW_W-1:0]   sw_cnt_q,  sw_cnt_d;
    logic [NUM_CH-1:0] sw_mask_q, sw_mask_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_cnt_q  <= '0;
            sw_mask_q <= '0;
        end else begin
            sw_cnt_q  <= sw_cnt_d;
            sw_mask_q <= sw_mask_d;
        end
    end
`else
    logic unused_sw;
    assign unused_sw = sw_rst_req ^ (^sw_rst_mask) ^ (SW_RST_CYC == 0);
`endif

    // ------------------------------------------------------------------
    // Sequencer state register and shadowed delays
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            rst_q    <= '1;
            busy     <= 1'b0;
            done     <= 1'b0;
            dly_sh_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            busy    <= busy_d;
            done    <= done_d;
            if (accept)
                dly_sh_q <= dly_in;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        busy_d  = busy;
        done_d  = done;
        accept  = 1'b0;
`ifdef UVMT_APB_ST_CLKNRST_CTRL_SW_RST_EN
        sw_cnt_d  = sw_cnt_q;
        sw_mask_d = sw_mask_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                // start has priority over a software reset request.
                if (start) begin
                    accept  = 1'b1;
                    state_d = RELEASE;
                    idx_d   = '0;
                    cnt_d   = dly_in[0];
                    rst_d   = '1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
`ifdef UVMT_APB_ST_CLKNRST_CTRL_SW_RST_EN
                else if (state_q == DONE && sw_rst_req && (|sw_rst_mask)) begin
                    state_d   = SWRST;
                    sw_mask_d = sw_rst_mask;
                    sw_cnt_d  = SW_W'(SW_RST_CYC - 1);
                    rst_d     = rst_q | sw_rst_mask;
                    busy_d    = 1'b1;
                end
`endif
            end

            RELEASE: begin
                if (cnt_q == '0) begin
                    rst_d[idx_q] = 1'b0;
                    if (last) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = dly_sh_q[idx_q + IDX_W'(1)];
                    end
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                end
            end

`ifdef UVMT_APB_ST_CLKNRST_CTRL_SW_RST_EN
            SWRST: begin
                // Entry edge counts as the first pulse cycle.
                if (sw_cnt_q == '0) begin
                    rst_d   = rst_q & ~sw_mask_q;
                    state_d = DONE;
                    busy_d  = 1'b0;
                end else begin
                    sw_cnt_d = sw_cnt_q - SW_W'(1);
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    assign ch_reset   = rst_q;
    assign ch_reset_n = ~rst_q;

    // ------------------------------------------------------------------
    // Per-channel dividers: free-run everywhere except IDLE, phase-aligned
    // by the start accept.
    // ------------------------------------------------------------------
    logic run;
    assign run = (state_q != IDLE);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_div
        uvmt_apb_st_clknrst_div #(
            .DIV_W (DIV_W)
        ) u_div (
            .clk     (clk),
            .reset   (reset),
            .restart (accept),
            .run     (run),
            .ratio   (div_in[g]),
            .clk_en  (ch_clk_en[g])
        );
    end

endmodule
